// File: rtl/lab3_timer_tick_master.sv
// lab3_timer_tick_master
// Avalon-MM master for the interval timer slave: programs the period and
// control registers after reset, acknowledges every timer interrupt by
// clearing the status register, and counts ticks in a 4-digit BCD counter.
// Optional feature macro: LAB3_TICK_WDOG_EN (missed-tick watchdog with
// sticky fault flag and automatic timer reprogramming).
module lab3_timer_tick_master #(
    parameter longint unsigned PERIOD_COUNT = 64'd50000000
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic [2:0]  avm_address,
    output logic        avm_chipselect,
    output logic        avm_write_n,
    output logic [15:0] avm_writedata,
    input  logic        avm_waitrequest,
    input  logic        timer_irq,
    input  logic        run,
    input  logic        clr,
    output logic        cfg_done,
    output logic        tick,
    output logic [15:0] bcd,
    output logic        fault
);

    // Timer register word addresses and control value
    localparam logic [2:0]  ADDR_STATUS  = 3'd0;
    localparam logic [2:0]  ADDR_CONTROL = 3'd1;
    localparam logic [2:0]  ADDR_PERIODL = 3'd2;
    localparam logic [2:0]  ADDR_PERIODH = 3'd3;
    localparam logic [15:0] CTL_START_CONT_ITO = 16'h0007;

    // The timer counts from the period register down to zero inclusive
    localparam logic [31:0] PERIOD_M1 = 32'(PERIOD_COUNT - 64'd1);

`ifdef LAB3_TICK_WDOG_EN
    // Last watchdog value before a restart (two full periods without an irq)
    localparam logic [32:0] WDOG_LAST = 33'((64'd2 * PERIOD_COUNT) - 64'd1);
`endif

    typedef enum logic [2:0] {
        ST_RST,
        ST_CFG_PL,
        ST_CFG_PH,
        ST_CFG_CTL,
        ST_IDLE,
        ST_ACK
    } state_t;

    state_t      state_q, state_d;
    logic        cfg_done_q, cfg_done_d;
    logic        tick_q, tick_d;
    logic [15:0] bcd_q, bcd_d;
    logic [15:0] bcd_inc;
    logic        carry;
    logic        wr_accept;
    logic        ack_accept;
    logic        bump;

`ifdef LAB3_TICK_WDOG_EN
    logic [32:0] wdog_q, wdog_d;
    logic        fault_q, fault_d;
`endif

    // Moore decode of the bus outputs from the state register
    always_comb begin
        avm_chipselect = 1'b0;
        avm_write_n    = 1'b1;
        avm_address    = '0;
        avm_writedata  = '0;
        unique case (state_q)
            ST_CFG_PL: begin
                avm_chipselect = 1'b1;
                avm_write_n    = 1'b0;
                avm_address    = ADDR_PERIODL;
                avm_writedata  = PERIOD_M1[15:0];
            end
            ST_CFG_PH: begin
                avm_chipselect = 1'b1;
                avm_write_n    = 1'b0;
                avm_address    = ADDR_PERIODH;
                avm_writedata  = PERIOD_M1[31:16];
            end
            ST_CFG_CTL: begin
                avm_chipselect = 1'b1;
                avm_write_n    = 1'b0;
                avm_address    = ADDR_CONTROL;
                avm_writedata  = CTL_START_CONT_ITO;
            end
            ST_ACK: begin
                avm_chipselect = 1'b1;
                avm_write_n    = 1'b0;
                avm_address    = ADDR_STATUS;
                avm_writedata  = '0;
            end
            default: ;
        endcase
    end

    assign wr_accept  = avm_chipselect & ~avm_write_n & ~avm_waitrequest;
    assign ack_accept = (state_q == ST_ACK) & wr_accept;
    assign bump       = ack_accept & run;

    // Next-state logic; each write state advances only on an accepted write
    always_comb begin
        state_d    = state_q;
        cfg_done_d = cfg_done_q;
`ifdef LAB3_TICK_WDOG_EN
        // Counter is zero everywhere outside IDLE, so it starts clean on entry
        wdog_d     = '0;
        fault_d    = fault_q;
`endif
        unique case (state_q)
            ST_RST: begin
                state_d = ST_CFG_PL;
            end
            ST_CFG_PL: begin
                if (wr_accept) state_d = ST_CFG_PH;
            end
            ST_CFG_PH: begin
                if (wr_accept) state_d = ST_CFG_CTL;
            end
            ST_CFG_CTL: begin
                if (wr_accept) begin
                    state_d    = ST_IDLE;
                    cfg_done_d = 1'b1;
                end
            end
            ST_IDLE: begin
                if (timer_irq) begin
                    state_d = ST_ACK;
                end
`ifdef LAB3_TICK_WDOG_EN
                else if (wdog_q == WDOG_LAST) begin
                    state_d    = ST_RST;
                    fault_d    = 1'b1;
                    cfg_done_d = 1'b0;
                end else begin
                    wdog_d = wdog_q + 33'd1;
                end
`endif
            end
            ST_ACK: begin
                if (wr_accept) state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_RST;
            end
        endcase
    end

    // Decimal increment of the tick count; 9999 rolls over to 0000
    always_comb begin
        bcd_inc = bcd_q;
        carry   = 1'b1;
        for (int unsigned i = 0; i < 4; i++) begin
            if (carry) begin
                if (bcd_q[4*i +: 4] == 4'd9) begin
                    bcd_inc[4*i +: 4] = 4'd0;
                end else begin
                    bcd_inc[4*i +: 4] = bcd_q[4*i +: 4] + 4'd1;
                    carry             = 1'b0;
                end
            end
        end
    end

    // Count event on status-clear acceptance; clr overrides the increment
    // but the tick pulse still reports the counted interrupt
    always_comb begin
        tick_d = bump;
        bcd_d  = bcd_q;
        if (clr) begin
            bcd_d = '0;
        end else if (bump) begin
            bcd_d = bcd_inc;
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_RST;
            cfg_done_q <= 1'b0;
            tick_q     <= 1'b0;
            bcd_q      <= '0;
        end else begin
            state_q    <= state_d;
            cfg_done_q <= cfg_done_d;
            tick_q     <= tick_d;
            bcd_q      <= bcd_d;
        end
    end

`ifdef LAB3_TICK_WDOG_EN
    // Watchdog counter and sticky fault flag
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wdog_q  <= '0;
            fault_q <= 1'b0;
        end else begin
            wdog_q  <= wdog_d;
            fault_q <= fault_d;
        end
    end

    assign fault = fault_q;
`else
    assign fault = 1'b0;
`endif

    assign cfg_done = cfg_done_q;
    assign tick     = tick_q;
    assign bcd      = bcd_q;

endmodule

// File: tb/tb_lab3_timer_tick_master.sv
// Testbench for lab3_timer_tick_master (PERIOD_COUNT=100).
// Table-driven tick vectors, directed configuration/stall/reset sequences,
// randomized ticks against an integer tick-count reference model, and
// BCD wrap checks. Watchdog sequence is built when LAB3_TICK_WDOG_EN is set.
module tb_lab3_timer_tick_master;

    localparam longint unsigned PERIOD = 64'd100;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic [2:0]  avm_address;
    logic        avm_chipselect;
    logic        avm_write_n;
    logic [15:0] avm_writedata;
    logic        avm_waitrequest = 1'b0;
    logic        timer_irq = 1'b0;
    logic        run = 1'b0;
    logic        clr = 1'b0;
    logic        cfg_done;
    logic        tick;
    logic [15:0] bcd;
    logic        fault;

    always #5 clk = ~clk;

    lab3_timer_tick_master #(.PERIOD_COUNT(PERIOD)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .avm_address     (avm_address),
        .avm_chipselect  (avm_chipselect),
        .avm_write_n     (avm_write_n),
        .avm_writedata   (avm_writedata),
        .avm_waitrequest (avm_waitrequest),
        .timer_irq       (timer_irq),
        .run             (run),
        .clr             (clr),
        .cfg_done        (cfg_done),
        .tick            (tick),
        .bcd             (bcd),
        .fault           (fault)
    );

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    int unsigned model_cnt = 0;
    int unsigned acc_cnt[8];

    // Bus monitor: inputs change just after posedge, so at negedge the
    // handshake seen here is the one the next posedge accepts
    always @(negedge clk) begin
        if (reset_n && avm_chipselect && !avm_write_n && !avm_waitrequest)
            acc_cnt[avm_address]++;
    end

    initial begin
        #3000000;
        $display("FAIL global_timeout: simulation did not finish, required finish before limit");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] to_bcd(input int unsigned n);
        logic [15:0] r;
        r[15:12] = 4'((n / 1000) % 10);
        r[11:8]  = 4'((n / 100) % 10);
        r[7:4]   = 4'((n / 10) % 10);
        r[3:0]   = 4'(n % 10);
        return r;
    endfunction

    function automatic logic [31:0] bus();
        return 32'({avm_chipselect, avm_write_n, avm_address, avm_writedata});
    endfunction

    function automatic logic [31:0] wr(input logic [2:0] a, input logic [15:0] d);
        return 32'({1'b1, 1'b0, a, d});
    endfunction

    // One interrupt serviced from IDLE: raise irq, optionally stall the
    // status write, apply run/clr on the acceptance edge
    task automatic do_tick(input logic r, input logic c, input int unsigned stall,
                           input bit check, output logic t_o, output logic [15:0] b_o);
        int unsigned acks0;
        acks0     = acc_cnt[0];
        run       = r;
        timer_irq = 1'b1;
        cyc();
        if (check) chk("ack_bus", bus(), wr(3'd0, 16'h0000));
        if (stall != 0) begin
            avm_waitrequest = 1'b1;
            for (int unsigned k = 0; k < stall; k++) begin
                cyc();
                if (check) chk("ack_hold", bus(), wr(3'd0, 16'h0000));
            end
            avm_waitrequest = 1'b0;
        end
        clr = c;
        cyc();
        timer_irq = 1'b0;
        clr       = 1'b0;
        if (c) model_cnt = 0;
        else if (r) model_cnt = (model_cnt + 1) % 10000;
        t_o = tick;
        b_o = bcd;
        if (check) begin
            chk("tick_on_ack", 32'(tick), 32'(r));
            chk("bcd_model", 32'(bcd), 32'(to_bcd(model_cnt)));
            chk("ack_once", acc_cnt[0] - acks0, 32'd1);
            cyc();
            chk("tick_clear", 32'(tick), 32'd0);
            chk("no_reack", 32'(avm_chipselect), 32'd0);
        end
    endtask

    typedef struct {
        logic        run;
        logic        clr;
        int unsigned stall;
        logic [15:0] exp_bcd;
        logic        exp_tick;
    } vec_t;

    initial begin
        vec_t        vecs[8];
        logic        t_o;
        logic [15:0] b_o;
        int unsigned a0, a1, a2, a3;

        // Starting from bcd=0x0001 after the first directed tick
        vecs[0] = '{run: 1'b1, clr: 1'b0, stall: 0, exp_bcd: 16'h0002, exp_tick: 1'b1};
        vecs[1] = '{run: 1'b1, clr: 1'b0, stall: 3, exp_bcd: 16'h0003, exp_tick: 1'b1};
        vecs[2] = '{run: 1'b0, clr: 1'b0, stall: 0, exp_bcd: 16'h0003, exp_tick: 1'b0};
        vecs[3] = '{run: 1'b0, clr: 1'b0, stall: 2, exp_bcd: 16'h0003, exp_tick: 1'b0};
        vecs[4] = '{run: 1'b0, clr: 1'b0, stall: 0, exp_bcd: 16'h0003, exp_tick: 1'b0};
        vecs[5] = '{run: 1'b1, clr: 1'b1, stall: 0, exp_bcd: 16'h0000, exp_tick: 1'b1};
        vecs[6] = '{run: 1'b1, clr: 1'b0, stall: 1, exp_bcd: 16'h0001, exp_tick: 1'b1};
        vecs[7] = '{run: 1'b0, clr: 1'b1, stall: 0, exp_bcd: 16'h0000, exp_tick: 1'b0};

        // Reset state
        reset_n = 1'b0;
        repeat (2) cyc();
        chk("rst_bus", bus(), 32'({1'b0, 1'b1, 3'd0, 16'h0000}));
        chk("rst_cfg_done", 32'(cfg_done), 32'd0);
        chk("rst_tick", 32'(tick), 32'd0);
        chk("rst_bcd", 32'(bcd), 32'd0);
        chk("rst_fault", 32'(fault), 32'd0);
        reset_n = 1'b1;

        // Configuration with no stall: three writes on consecutive cycles
        cyc();
        chk("cfg_pl", bus(), wr(3'd2, 16'h0063));
        cyc();
        chk("cfg_ph", bus(), wr(3'd3, 16'h0000));
        cyc();
        chk("cfg_ctl", bus(), wr(3'd1, 16'h0007));
        chk("cfg_done_early", 32'(cfg_done), 32'd0);
        cyc();
        chk("cfg_done", 32'(cfg_done), 32'd1);
        chk("cfg_idle_bus", 32'(avm_chipselect), 32'd0);

        // Single interrupt with run=1
        do_tick(1'b1, 1'b0, 0, 1'b1, t_o, b_o);
        chk("first_tick", 32'(t_o), 32'd1);
        chk("first_bcd", 32'(b_o), 32'h0001);

        // Table-driven tick vectors
        a0 = acc_cnt[0];
        for (int i = 0; i < 8; i++) begin
            do_tick(vecs[i].run, vecs[i].clr, vecs[i].stall, 1'b1, t_o, b_o);
            chk($sformatf("vec%0d_bcd", i), 32'(b_o), 32'(vecs[i].exp_bcd));
            chk($sformatf("vec%0d_tick", i), 32'(t_o), 32'(vecs[i].exp_tick));
        end
        chk("vec_ack_total", acc_cnt[0] - a0, 32'd8);

        // Randomized ticks with idle gaps and stray clears
        for (int i = 0; i < 150; i++) begin
            int unsigned gap;
            gap = $urandom_range(3, 0);
            for (int unsigned g = 0; g < gap; g++) begin
                logic cg;
                cg  = ($urandom_range(7, 0) == 0);
                clr = cg;
                cyc();
                clr = 1'b0;
                if (cg) model_cnt = 0;
                chk("gap_bcd", 32'(bcd), 32'(to_bcd(model_cnt)));
                chk("gap_tick", 32'(tick), 32'd0);
            end
            do_tick(1'($urandom_range(1, 0)), ($urandom_range(4, 0) == 0),
                    $urandom_range(2, 0), 1'b1, t_o, b_o);
        end
        chk("rand_cfg_done", 32'(cfg_done), 32'd1);

        // Asynchronous reset from IDLE clears the count at once
        if (model_cnt == 0) do_tick(1'b1, 1'b0, 0, 1'b1, t_o, b_o);
        reset_n = 1'b0;
        #1;
        chk("async_rst_bcd", 32'(bcd), 32'd0);
        model_cnt = 0;
        cyc();
        reset_n = 1'b1;
        cyc();
        cyc();
        // Now presenting the PH write; reset mid-write forces an idle bus
        chk("pre_rst_ph", bus(), wr(3'd3, 16'h0000));
        reset_n = 1'b0;
        #1;
        chk("midwrite_rst_bus", bus(), 32'({1'b0, 1'b1, 3'd0, 16'h0000}));
        chk("midwrite_rst_cfg", 32'(cfg_done), 32'd0);
        cyc();

        // Restart from CFG_PL with a 3-cycle stall during CFG_PH
        a1 = acc_cnt[1];
        a2 = acc_cnt[2];
        a3 = acc_cnt[3];
        reset_n = 1'b1;
        cyc();
        chk("restart_pl", bus(), wr(3'd2, 16'h0063));
        cyc();
        chk("stall_ph0", bus(), wr(3'd3, 16'h0000));
        avm_waitrequest = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            cyc();
            chk($sformatf("stall_ph%0d", k), bus(), wr(3'd3, 16'h0000));
        end
        avm_waitrequest = 1'b0;
        cyc();
        chk("stall_ctl", bus(), wr(3'd1, 16'h0007));
        chk("stall_cfg_done_early", 32'(cfg_done), 32'd0);
        cyc();
        chk("stall_cfg_done", 32'(cfg_done), 32'd1);
        chk("stall_pl_once", acc_cnt[2] - a2, 32'd1);
        chk("stall_ph_once", acc_cnt[3] - a3, 32'd1);
        chk("stall_ctl_once", acc_cnt[1] - a1, 32'd1);

        // Carry through three digits, then 9999 -> 0000
        for (int i = 0; i < 999; i++) do_tick(1'b1, 1'b0, 0, 1'b0, t_o, b_o);
        chk("bcd_0999", 32'(bcd), 32'h0999);
        do_tick(1'b1, 1'b0, 0, 1'b1, t_o, b_o);
        chk("bcd_1000", 32'(b_o), 32'h1000);
        for (int i = 0; i < 10000 && model_cnt != 9999; i++)
            do_tick(1'b1, 1'b0, 0, 1'b0, t_o, b_o);
        chk("bcd_9999", 32'(bcd), 32'h9999);
        do_tick(1'b1, 1'b0, 0, 1'b1, t_o, b_o);
        chk("bcd_wrap", 32'(b_o), 32'h0000);
        chk("wrap_tick", 32'(t_o), 32'd1);
        chk("no_fault", 32'(fault), 32'd0);

`ifdef LAB3_TICK_WDOG_EN
        // Missed ticks: 200 IDLE cycles without irq restart the configuration
        do_tick(1'b1, 1'b0, 0, 1'b1, t_o, b_o);
        repeat (198) cyc();
        chk("wdog_fault_early", 32'(fault), 32'd0);
        chk("wdog_cfg_early", 32'(cfg_done), 32'd1);
        cyc();
        chk("wdog_fault", 32'(fault), 32'd1);
        chk("wdog_cfg_done", 32'(cfg_done), 32'd0);
        cyc();
        chk("wdog_pl", bus(), wr(3'd2, 16'h0063));
        cyc();
        chk("wdog_ph", bus(), wr(3'd3, 16'h0000));
        cyc();
        chk("wdog_ctl", bus(), wr(3'd1, 16'h0007));
        cyc();
        chk("wdog_recfg", 32'(cfg_done), 32'd1);
        chk("wdog_sticky", 32'(fault), 32'd1);
        chk("wdog_bcd_kept", 32'(bcd), 32'h0001);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/lab3_timer_tick_master.md
# lab3_timer_tick_master

Avalon-MM master that sits directly upstream of the interval timer slave and drives its register port. After reset it programs the timer's period and control registers. It then services every timer interrupt by clearing the timer's status register, and counts the resulting ticks in a 4-digit BCD counter that feeds the seven-segment display path. No CPU is needed to run the timebase.

## Interface
Parameters:
- PERIOD_COUNT, default 50000000: timer clocks per tick. The block writes PERIOD_COUNT-1 to the timer period registers. Legal range is 2..2^32.

Ports:
- clk, input, 1: system clock.
- reset_n, input, 1: asynchronous, active-low reset.
- avm_address, output, 3: timer register word address.
- avm_chipselect, output, 1: timer select.
- avm_write_n, output, 1: active-low write strobe.
- avm_writedata, output, 16: write data.
- avm_waitrequest, input, 1: interconnect stall. While it is high, the write is held.
- timer_irq, input, 1: timer interrupt, level, active high.
- run, input, 1: count enable. While low, ticks are acknowledged but not counted.
- clr, input, 1: synchronous clear of the BCD count.
- cfg_done, output, 1: timer programmed and running.
- tick, output, 1: one-cycle pulse for each counted tick.
- bcd, output, 16: four BCD digits. Digit 3 is in [15:12], digit 0 is in [3:0].
- fault, output, 1: sticky missed-tick flag. Only active with the watchdog macro.

## Operation
States are RST, CFG_PL, CFG_PH, CFG_CTL, IDLE and ACK. The Avalon outputs are a Moore decode of the state register.
- RST: bus idle (chipselect=0, write_n=1, address=0, writedata=0). Moves unconditionally to CFG_PL.
- CFG_PL: writes address 2 with data PERIOD_COUNT-1 [15:0].
- CFG_PH: writes address 3 with data PERIOD_COUNT-1 [31:16].
- CFG_CTL: writes address 1 with data 0x0007 (START, CONT, ITO). On acceptance, cfg_done is set to 1 and the FSM moves to IDLE.
- IDLE: bus idle. When timer_irq=1, moves to ACK.
- ACK: writes address 0 with data 0x0000, which clears the timeout status. On acceptance, moves to IDLE and performs a count event.

Write and handshake rules:
- A write is accepted on a rising edge where chipselect=1, write_n=0 and avm_waitrequest=0.
- While avm_waitrequest=1, address, data and strobes hold stable and the state does not advance.
- Each write state presents exactly one accepted write.

Count event (ACK acceptance edge):
- If run=1: bcd increments in decimal. Each digit wraps 9 to 0 and carries into the next digit. 9999 wraps to 0000.
- tick is high for the cycle following that edge only when an increment occurred.
- If run=0: the timer is still acknowledged; bcd holds and tick stays 0.

clr behaviour:
- clr=1 at an edge forces bcd to 0000.
- clr takes priority over a simultaneous increment. In that case bcd=0000 and tick still pulses.

cfg_done stays at 1 until reset, or until a watchdog restart (see Configuration).

## Timing
Reset values:
- State is RST; all Avalon outputs are idle.
- cfg_done=0, tick=0, bcd=0x0000, fault=0.

With avm_waitrequest=0 throughout:
- Edge 1 after reset release: enter CFG_PL.
- Edges 2, 3 and 4 accept the PL, PH and CTL writes.
- cfg_done=1 from the cycle after edge 4.

Interrupt service:
- timer_irq is sampled in IDLE.
- The status write is on the bus in the next cycle; minimum IRQ-to-clear latency is 2 edges.
- Once the write is accepted, timer_irq is low in the following IDLE cycle.
- No second acknowledge occurs for the same interrupt.

Stalls add cycles one for one. The block never drops or duplicates a write.

Reset asserted mid-write forces RST immediately (asynchronous reset). The next configuration restarts from CFG_PL.

## Configuration
Macro: LAB3_TICK_WDOG_EN.
- Defined: a 33-bit watchdog counter runs.
  - It clears on entry to IDLE and increments in each IDLE cycle with timer_irq=0.
  - On reaching 2*PERIOD_COUNT, fault is set (sticky until reset), cfg_done is cleared, and the FSM goes to RST to reprogram the timer.
  - bcd is preserved across this restart.
- Not defined: no watchdog logic. fault is tied to 0, and IDLE waits indefinitely.

## Test plan
- PERIOD_COUNT=100, no stall, after reset:
  - Writes must be (2,0x0063), (3,0x0000), (1,0x0007) on consecutive cycles.
  - cfg_done must be 1 one cycle after the CTL write.
- avm_waitrequest held high for 3 cycles during CFG_PH: address and data stay at (3,0x0000) for 4 cycles, and exactly one PH write is accepted.
- timer_irq pulse with run=1: the status write (0,0x0000) follows 2 edges later, tick pulses once, and bcd goes 0x0000 to 0x0001.
- Count wrap and clr:
  - Preload bcd to 0x0999 with 999 ticks; the next tick gives 0x1000.
  - At 0x9999, the next tick gives 0x0000.
  - clr coincident with a tick gives 0x0000 with tick=1.
- run=0 with 3 interrupts: 3 status writes occur, bcd is unchanged, and tick stays 0.
- With LAB3_TICK_WDOG_EN, PERIOD_COUNT=100, timer_irq held 0: after 200 IDLE cycles, fault=1, cfg_done=0, and the 3-write configuration sequence repeats.
